// File: rtl/pixel_write_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_write_unit                                             |
// | Description : Clips incoming pixels to the framebuffer, converts them to   |
// |               byte addresses, buffers them and issues one 32-bit memory    |
// |               write per pixel over a req/ack handshake.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_write_unit #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  input  logic [31:0]      pixel_x,
  input  logic [31:0]      pixel_y,
  input  logic [31:0]      pixel_color,
  input  logic [31:0]      fb_base,
  input  logic [31:0]      fb_stride,
  input  logic [31:0]      fb_width,
  input  logic [31:0]      fb_height,
  output logic             mem_wr_req,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  input  logic             mem_wr_ack,
  output logic             idle,
  output logic [CNT_W-1:0] drop_count
);

  localparam int               c_ptr_w    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               c_occ_w    = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_occ_w-1:0] c_occ_one  = c_occ_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Output write register and FSM
  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;

  // Address staging register between accept and FIFO write
  logic               stg_vld_q, stg_vld_d;
  logic [31:0]        stg_addr_q, stg_addr_d;
  logic [31:0]        stg_data_q, stg_data_d;

  // FIFO bookkeeping
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic [c_occ_w-1:0] occ_q, occ_d;
  logic [31:0]        fifo_addr_q [FIFO_DEPTH];
  logic [31:0]        fifo_data_q [FIFO_DEPTH];

  logic               idle_q, idle_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               w_accept;
  logic               w_clip;
  logic               w_keep;
  logic               w_pop;
  logic [31:0]        w_lin;

  // Input side: handshake, clip test, address computation and drop counter
  always_comb begin
    w_accept   = pixel_valid && !full_q;
    w_clip     = (pixel_x >= fb_width) || (pixel_y >= fb_height);
    w_keep     = w_accept && !w_clip;
    w_lin      = pixel_y * fb_stride + pixel_x;
    stg_vld_d  = w_keep;
    stg_addr_d = stg_addr_q;
    stg_data_d = stg_data_q;
    drop_d     = drop_q;
    if (w_keep) begin
      stg_addr_d = fb_base + (w_lin << 2);
      stg_data_d = pixel_color;
    end
    if (w_accept && w_clip && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  // Output FSM: load the FIFO head into the write register, hold until ack
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          w_pop   = 1'b1;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_wr_ack) begin
          if (!empty_q) begin
            w_pop = 1'b1;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (w_pop) begin
      addr_d = fifo_addr_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // FIFO pointers, flags and occupancy; occupancy includes the staging slot so
  // a staged pixel always finds room in the FIFO on the following cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    empty_d  = empty_q;
    occ_d    = occ_q;
    if (stg_vld_q) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (w_pop)     rd_ptr_d = rd_ptr_q + c_ptr_one;
    if (stg_vld_q && !w_pop) begin
      empty_d = 1'b0;
    end else if (w_pop && !stg_vld_q) begin
      empty_d = (rd_ptr_q + c_ptr_one) == wr_ptr_q;
    end
    if (w_keep && !w_pop) begin
      occ_d = occ_q + c_occ_one;
    end else if (w_pop && !w_keep) begin
      occ_d = occ_q - c_occ_one;
    end
    full_d = (occ_d == c_occ_full);
    idle_d = (occ_d == '0) && (state_d == ST_IDLE);
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      occ_q      <= '0;
      idle_q     <= 1'b1;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      stg_vld_q  <= stg_vld_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      occ_q      <= occ_d;
      idle_q     <= idle_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (stg_vld_q) begin
      fifo_addr_q[wr_ptr_q] <= stg_addr_q;
      fifo_data_q[wr_ptr_q] <= stg_data_q;
    end
  end

  assign pixel_ready = !full_q;
  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign idle        = idle_q;
  assign drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_write_unit                                          |
// | Description : Directed self-checking bench for pixel_write_unit.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_write_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [31:0] pixel_x = '0;
  logic [31:0] pixel_y = '0;
  logic [31:0] pixel_color = '0;
  logic [31:0] fb_base = 32'h1000_0000;
  logic [31:0] fb_stride = 32'd640;
  logic [31:0] fb_width = 32'd640;
  logic [31:0] fb_height = 32'd480;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic        idle;
  logic [15:0] drop_count;

  int          n_total = 0;
  int          n_bad = 0;
  int          stall_cnt = 0;
  logic [63:0] wr_log [$];

  pixel_write_unit #(.FIFO_DEPTH(8), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .fb_base     (fb_base),
    .fb_stride   (fb_stride),
    .fb_width    (fb_width),
    .fb_height   (fb_height),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ack  (mem_wr_ack),
    .idle        (idle),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Log every completed write (req and ack both high at the coming edge)
  always @(negedge clk) begin
    if (rst_n && mem_wr_req && mem_wr_ack) wr_log.push_back({mem_wr_addr, mem_wr_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    bit done = 0;
    pixel_valid = 1'b1;
    pixel_x     = x;
    pixel_y     = y;
    pixel_color = c;
    for (int k = 0; k < 200 && !done; k++) begin
      if (pixel_ready) done = 1;
      else stall_cnt++;
      tick();
    end
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int k = 0; k < 200; k++) begin
      if (wr_log.size() >= n) break;
      tick();
    end
    chk(tag, 64'(wr_log.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [31:0] row_base [3];
  logic [31:0] p_x [12];
  logic [31:0] p_y [12];
  logic [31:0] p_c [12];

  initial begin
    int idx;
    int unstable;
    bit r;
    row_base[0] = 32'h1000_0000;
    row_base[1] = 32'h1000_0A00;
    row_base[2] = 32'h1000_1400;

    do_reset();
    chk("rst_req", 64'(mem_wr_req), 64'd0);
    chk("rst_addr", 64'(mem_wr_addr), 64'd0);
    chk("rst_data", 64'(mem_wr_data), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_ready", 64'(pixel_ready), 64'd1);

    // 1: single pixel, latency
    mem_wr_ack = 1'b1;
    wr_log.delete();
    push_px(32'd3, 32'd2, 32'hA5A5_A5A5);
    pixel_valid = 1'b0;
    chk("t1_req_n0", 64'(mem_wr_req), 64'd0);
    tick();
    chk("t1_req_n1", 64'(mem_wr_req), 64'd0);
    tick();
    chk("t1_req_n2", 64'(mem_wr_req), 64'd1);
    chk("t1_addr", 64'(mem_wr_addr), 64'h1000_140C);
    chk("t1_data", 64'(mem_wr_data), 64'hA5A5_A5A5);
    tick();
    chk("t1_req_drop", 64'(mem_wr_req), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);
    chk("t1_count", 64'(wr_log.size()), 64'd1);

    // 2: 4x3 raster, ack tied high
    wr_log.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) push_px(32'(x), 32'(y), 32'hA5A5_A5A5);
    pixel_valid = 1'b0;
    wait_writes("t2_nwr", 12);
    for (int i = 0; i < 12 && i < wr_log.size(); i++)
      chk($sformatf("t2_wr%0d", i), wr_log[i], {row_base[i/4] + 32'(4*(i%4)), 32'hA5A5_A5A5});
    repeat (2) tick();
    chk("t2_idle", 64'(idle), 64'd1);

    // 3: backpressure with ack low for 20 cycles
    for (int i = 0; i < 12; i++) begin
      p_x[i] = 32'(i % 4);
      p_y[i] = 32'(i / 4);
      p_c[i] = 32'hC0DE_0000 | 32'(i);
    end
    wr_log.delete();
    mem_wr_ack = 1'b0;
    idx = 0;
    unstable = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      pixel_valid = (idx < 12);
      if (idx < 12) begin
        pixel_x = p_x[idx]; pixel_y = p_y[idx]; pixel_color = p_c[idx];
      end
      r = pixel_ready;
      if (mem_wr_req && (mem_wr_addr !== 32'h1000_0000 || mem_wr_data !== p_c[0])) unstable++;
      tick();
      if (r && idx < 12) idx++;
    end
    pixel_valid = 1'b0;
    chk("t3_accepted", 64'(idx), 64'd9);
    chk("t3_ready_low", 64'(pixel_ready), 64'd0);
    chk("t3_req_held", 64'(mem_wr_req), 64'd1);
    chk("t3_stable", 64'(unstable), 64'd0);
    chk("t3_no_wr", 64'(wr_log.size()), 64'd0);
    mem_wr_ack = 1'b1;
    for (int i = idx; i < 12; i++) push_px(p_x[i], p_y[i], p_c[i]);
    pixel_valid = 1'b0;
    wait_writes("t3_nwr", 12);
    for (int i = 0; i < 12 && i < wr_log.size(); i++)
      chk($sformatf("t3_wr%0d", i), wr_log[i], {row_base[i/4] + 32'(4*(i%4)), p_c[i]});

    // 4: clipping
    repeat (3) tick();
    wr_log.delete();
    stall_cnt = 0;
    push_px(32'd640, 32'd0, 32'h1111_1111);
    push_px(32'd1, 32'd1, 32'h2222_2222);
    push_px(32'd0, 32'd480, 32'h3333_3333);
    pixel_valid = 1'b0;
    wait_writes("t4_nwr", 1);
    repeat (5) tick();
    chk("t4_only_one", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0) chk("t4_wr", wr_log[0], {32'h1000_0A04, 32'h2222_2222});
    chk("t4_drop", 64'(drop_count), 64'd2);
    chk("t4_no_stall", 64'(stall_cnt), 64'd0);

    // 5: reset while a write is outstanding
    wr_log.delete();
    mem_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) push_px(32'(i), 32'd5, 32'h5555_0000 | 32'(i));
    pixel_valid = 1'b0;
    repeat (3) tick();
    chk("t5_pre_req", 64'(mem_wr_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_req", 64'(mem_wr_req), 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);
    chk("t5_drop", 64'(drop_count), 64'd0);
    chk("t5_ready", 64'(pixel_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    mem_wr_ack = 1'b1;
    repeat (20) tick();
    chk("t5_no_wr", 64'(wr_log.size()), 64'd0);
    chk("t5_req_after", 64'(mem_wr_req), 64'd0);

    // 6: address wrap and drop counter saturation
    fb_base = 32'hFFFF_FFF0;
    push_px(32'd8, 32'd0, 32'h1234_5678);
    pixel_valid = 1'b0;
    wait_writes("t6_nwr", 1);
    if (wr_log.size() > 0) chk("t6_wrap", wr_log[0], {32'h0000_0010, 32'h1234_5678});
    stall_cnt = 0;
    pixel_valid = 1'b1;
    pixel_x     = 32'd1000;
    pixel_y     = 32'd0;
    for (int i = 0; i < 65541; i++) begin
      if (!pixel_ready) stall_cnt++;
      tick();
      if (i == 65533) chk("t6_drop_fffe", 64'(drop_count), 64'hFFFE);
    end
    pixel_valid = 1'b0;
    tick();
    chk("t6_drop_sat", 64'(drop_count), 64'hFFFF);
    chk("t6_no_stall", 64'(stall_cnt), 64'd0);
    chk("t6_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
